// File: rtl/tick_scheduler.sv
// Shared-tick event scheduler: NCH periodic channels counted in tick_in pulses,
// served to one valid/ready port by a round-robin arbiter. Define TICK_SCHED_OVERRUN_EN to build overrun flags.
module tick_scheduler #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_in,
    input  logic                   cfg_wr,
    input  logic [$clog2(NCH)-1:0] cfg_ch,
    input  logic [CW-1:0]          cfg_period,
    output logic                   evt_valid,
    output logic [$clog2(NCH)-1:0] evt_ch,
    input  logic                   evt_ready,
    output logic [NCH-1:0]         pending,
    output logic [NCH-1:0]         overrun
);

    localparam int unsigned CHW = $clog2(NCH);

    logic [CW-1:0]  per [NCH];
    logic [CW-1:0]  cnt [NCH];
    logic [NCH-1:0] pend;
    logic [CHW-1:0] last;

    logic           port_free;
    logic           sel_vld;
    logic [CHW-1:0] sel_ch;
    logic [CHW-1:0] idx;
    logic [NCH-1:0] cfg_hit;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] sel_oh;

    // Round-robin search starting just after the last granted channel
    always_comb begin
        port_free = !evt_valid || evt_ready;
        sel_vld   = 1'b0;
        sel_ch    = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = last + CHW'(k);
            if (!sel_vld && pend[idx]) begin
                sel_vld = 1'b1;
                sel_ch  = idx;
            end
        end
    end

    // Per-channel strobes; a config write suppresses that channel's expiry
    always_comb begin
        cfg_hit = '0;
        expire  = '0;
        sel_oh  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cfg_hit[i] = cfg_wr && (cfg_ch == CHW'(i));
            expire[i]  = !cfg_hit[i] && tick_in && (per[i] != '0) && (cnt[i] == CW'(1));
            sel_oh[i]  = port_free && sel_vld && (sel_ch == CHW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                per[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_hit[i]) begin
                    per[i] <= cfg_period;
                    cnt[i] <= cfg_period;
                end else if (tick_in && (per[i] != '0)) begin
                    cnt[i] <= (cnt[i] == CW'(1)) ? per[i] : cnt[i] - CW'(1);
                end
            end
        end
    end

    // A new expiry outranks the clear from selection in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_hit[i])      pend[i] <= 1'b0;
                else if (expire[i])  pend[i] <= 1'b1;
                else if (sel_oh[i])  pend[i] <= 1'b0;
            end
        end
    end

`ifdef TICK_SCHED_OVERRUN_EN
    logic [NCH-1:0] ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (cfg_hit[i])                              ovr[i] <= 1'b0;
                else if (expire[i] && pend[i] && !sel_oh[i]) ovr[i] <= 1'b1;
            end
        end
    end

    assign overrun = ovr;
`else
    assign overrun = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            last      <= CHW'(NCH - 1);
        end else if (port_free) begin
            evt_valid <= sel_vld;
            if (sel_vld) begin
                evt_ch <= sel_ch;
                last   <= sel_ch;
            end
        end
    end

    assign pending = pend;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected event channels are queued as
// stimulus is driven and popped on each accepted handshake.
module tb_tick_scheduler;

`ifdef TICK_SCHED_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_in = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic        evt_valid;
    logic [1:0]  evt_ch;
    logic        evt_ready = 1'b0;
    logic [3:0]  pending;
    logic [3:0]  overrun;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    tick_scheduler #(.NCH(4), .CW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted event must match the oldest expected channel
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            int e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD;
            checks++;
            assert (32'(evt_ch) === e) else begin
                errors++;
                $error("FAIL evt_accept: observed=%0h expected=%0h", evt_ch, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [15:0] period);
        cfg_wr = 1'b1;
        cfg_ch = ch;
        cfg_period = period;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic tick_pulse();
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $error("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset values
        step();
        step();
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ch", 32'(evt_ch), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        step();

        // Period 3 with ready held: one event after every third tick
        evt_ready = 1'b1;
        cfg_write(2'd0, 16'd3);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(0);
            tick_pulse();
            tick_pulse();
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            check("p3_pend_set", 32'(pending), 32'h1);
            check("p3_valid_lat", 32'(evt_valid), 0);
            step();
            check("p3_valid", 32'(evt_valid), 1);
            check("p3_ch", 32'(evt_ch), 0);
            check("p3_pend_clr", 32'(pending), 0);
            step();
            check("p3_valid_drop", 32'(evt_valid), 0);
        end

        // All channels period 1 with ready low: everything pending and overrun
        do_reset();
        evt_ready = 1'b0;
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 16'd1);
        tick_pulse();
        tick_pulse();
        tick_pulse();
        check("all_pending", 32'(pending), 32'hF);
        check("all_overrun", 32'(overrun), OVR_EN ? 32'hF : 32'h0);
        check("all_valid", 32'(evt_valid), 1);
        check("all_ch", 32'(evt_ch), 0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        evt_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("drain_valid", 32'(evt_valid), 0);
        check("drain_pending", 32'(pending), 0);
        check("drain_overrun_sticky", 32'(overrun), OVR_EN ? 32'hF : 32'h0);
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 16'd0);
        check("cfg_clears_overrun", 32'(overrun), 0);

        // Round-robin: last=1, ch1 and ch2 pending -> ch2 first
        do_reset();
        check("q_empty_rr", 32'(exp_q.size()), 0);
        evt_ready = 1'b1;
        cfg_write(2'd1, 16'd1);
        exp_q.push_back(1);
        tick_pulse();
        step();
        evt_ready = 1'b0;
        cfg_write(2'd2, 16'd1);
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        check("rr_pending", 32'(pending), 32'h6);
        step();
        check("rr_first", 32'(evt_ch), 2);
        check("rr_pending_left", 32'(pending), 32'h2);
        exp_q.push_back(2); exp_q.push_back(1);
        evt_ready = 1'b1;
        step();
        check("rr_second", 32'(evt_ch), 1);
        check("rr_second_valid", 32'(evt_valid), 1);
        step();
        check("rr_done", 32'(evt_valid), 0);

        // Hold stability while another channel expires
        do_reset();
        evt_ready = 1'b0;
        cfg_write(2'd2, 16'd1);
        cfg_write(2'd0, 16'd2);
        tick_pulse();
        tick_pulse();
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_valid", 32'(evt_valid), 1);
            check("hold_ch", 32'(evt_ch), 2);
            check("hold_pend0", 32'(pending[0]), 1);
        end
        exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
        evt_ready = 1'b1;
        step();
        check("hold_next_ch0", 32'(evt_ch), 0);
        step();
        check("hold_then_ch2", 32'(evt_ch), 2);
        step();
        check("hold_done", 32'(evt_valid), 0);
        check("hold_no_overrun", 32'(overrun), 0);

        // Config write coincident with expiry wins; then disable
        do_reset();
        evt_ready = 1'b1;
        cfg_write(2'd1, 16'd1);
        cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd5; tick_in = 1'b1;
        step();
        cfg_wr = 1'b0; tick_in = 1'b0;
        check("cw_no_pend", 32'(pending), 0);
        step();
        check("cw_no_event", 32'(evt_valid), 0);
        for (int k = 0; k < 4; k++) tick_pulse();
        check("cw_not_yet", 32'(pending), 0);
        exp_q.push_back(1);
        tick_in = 1'b1;
        step();
        tick_in = 1'b0;
        check("cw_expire5", 32'(pending), 32'h2);
        check("cw_overrun", 32'(overrun), 0);
        step();
        check("cw_valid", 32'(evt_valid), 1);
        check("cw_ch", 32'(evt_ch), 1);
        step();
        cfg_write(2'd1, 16'd0);
        for (int k = 0; k < 3; k++) tick_pulse();
        check("dis_valid", 32'(evt_valid), 0);
        check("dis_pending", 32'(pending), 0);

        // Async reset while ch3 is presented
        do_reset();
        evt_ready = 1'b0;
        cfg_write(2'd3, 16'd1);
        tick_pulse();
        tick_pulse();
        tick_pulse();
        check("pre_rst_valid", 32'(evt_valid), 1);
        check("pre_rst_ch", 32'(evt_ch), 3);
        check("pre_rst_overrun", 32'(overrun), OVR_EN ? 32'h8 : 32'h0);
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(evt_valid), 0);
        check("async_ch", 32'(evt_ch), 0);
        check("async_pending", 32'(pending), 0);
        check("async_overrun", 32'(overrun), 0);
        step();
        rst_n = 1'b1;
        step();
        check("q_empty_end", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
